// File: rtl/keypad_encoder.sv
// Keypad encoder: scans a 4x4 active-low key matrix, debounces each press and
// release, and turns every accepted key into the calculator controller's
// digit / operator / equal / clear strobes.
module keypad_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_pulse
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;
    typedef enum logic [2:0] {K_DIG, K_ADD, K_SUB, K_MUL, K_EQ, K_CLR, K_NONE} kind_t;

    state_t          st_q, st_d;
    logic [DW-1:0]   div_q;
    logic [1:0]      row_q, row_d;
    logic [1:0]      cand_q, cand_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tick;
    logic            col_any;
    logic [1:0]      col_idx;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_full;

    logic [3:0]      keypad_q;
    logic            read_q, equal_q, clear_q, after_eq_q;
    logic [2:0]      op_q;
    kind_t           kind;
    logic [3:0]      digit;

    assign tick     = (div_q == DW'(SCAN_DIV - 1));
    assign col_any  = (col_n != 4'hF);
    assign cnt_inc  = cnt_q + 1'b1;
    assign cnt_full = (cnt_inc == CW'(DEBOUNCE_SCANS));
    assign row_n    = ~(4'b0001 << row_q);

    // Lowest closed column wins when several read low together.
    always_comb begin
        col_idx = 2'd0;
        if      (!col_n[0]) col_idx = 2'd0;
        else if (!col_n[1]) col_idx = 2'd1;
        else if (!col_n[2]) col_idx = 2'd2;
        else if (!col_n[3]) col_idx = 2'd3;
    end

    // Free-running row-period divider; its last count is the sample tick.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)     div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + 1'b1;
    end

    // Scan/debounce state register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            st_q   <= SCAN;
            row_q  <= 2'd0;
            cand_q <= 2'd0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            row_q  <= row_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next state: the row only moves when the matrix is idle or a press falls through.
    always_comb begin
        st_d   = st_q;
        row_d  = row_q;
        cand_d = cand_q;
        cnt_d  = cnt_q;
        case (st_q)
            SCAN: if (tick) begin
                if (!col_any) begin
                    row_d = row_q + 2'd1;
                end else begin
                    cand_d = col_idx;
                    cnt_d  = CW'(1);
                    st_d   = (DEBOUNCE_SCANS == 1) ? EMIT : DEBOUNCE;
                end
            end
            DEBOUNCE: if (tick) begin
                if (col_any && col_idx == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_full) st_d = EMIT;
                end else begin
                    st_d  = SCAN;
                    row_d = row_q + 2'd1;
                end
            end
            EMIT: begin
                cnt_d = '0;
                st_d  = RELEASE;
            end
            RELEASE: if (tick) begin
                if (col_any) begin
                    cnt_d = '0;
                end else if (cnt_full) begin
                    cnt_d = '0;
                    st_d  = SCAN;
                    row_d = row_q + 2'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: st_d = SCAN;
        endcase
    end

    // Decode the held {row, col} into an action class and digit value.
    always_comb begin
        kind  = K_NONE;
        digit = 4'd0;
        case ({row_q, cand_q})
            4'h0: begin kind = K_DIG; digit = 4'd1; end
            4'h1: begin kind = K_DIG; digit = 4'd2; end
            4'h2: begin kind = K_DIG; digit = 4'd3; end
            4'h3: kind = K_ADD;
            4'h4: begin kind = K_DIG; digit = 4'd4; end
            4'h5: begin kind = K_DIG; digit = 4'd5; end
            4'h6: begin kind = K_DIG; digit = 4'd6; end
            4'h7: kind = K_SUB;
            4'h8: begin kind = K_DIG; digit = 4'd7; end
            4'h9: begin kind = K_DIG; digit = 4'd8; end
            4'hA: begin kind = K_DIG; digit = 4'd9; end
            4'hB: kind = K_MUL;
            4'hC: kind = K_CLR;
            4'hD: begin kind = K_DIG; digit = 4'd0; end
            4'hE: kind = K_EQ;
            default: kind = K_NONE;
        endcase
    end

    // Registered actions; strobes drop back to 0 the cycle after they fire.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            keypad_q   <= 4'd0;
            read_q     <= 1'b0;
            equal_q    <= 1'b0;
            clear_q    <= 1'b0;
            op_q       <= 3'b000;
            after_eq_q <= 1'b0;
        end else begin
            read_q  <= 1'b0;
            equal_q <= 1'b0;
            clear_q <= 1'b0;
            if (st_q == EMIT) begin
                case (kind)
                    K_DIG: begin
                        keypad_q <= digit;
                        read_q   <= 1'b1;
                        if (after_eq_q) begin
                            op_q       <= 3'b000;
                            after_eq_q <= 1'b0;
                        end
                    end
                    K_ADD: op_q <= 3'b001;
                    K_SUB: op_q <= 3'b010;
                    K_MUL: op_q <= 3'b100;
                    // Operator is kept so the controller can still read it with '='.
                    K_EQ: begin
                        equal_q    <= 1'b1;
                        after_eq_q <= 1'b1;
                    end
                    K_CLR: begin
                        clear_q    <= 1'b1;
                        op_q       <= 3'b000;
                        after_eq_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign keypad_input   = keypad_q;
    assign read_input     = read_q;
    assign operator_input = op_q;
    assign equal_input    = equal_q;
    assign clear_pulse    = clear_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A 16-bit key mask models the matrix: bit r*4+c closes key [r][c].
module tb_keypad_encoder;
    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] keypad_input;
    logic       read_input;
    logic [2:0] operator_input;
    logic       equal_input;
    logic       clear_pulse;
    logic [15:0] keys = 16'h0;

    int errs = 0;
    int checks = 0;

    // per-run_key observations
    int         reads, eqs, clrs, multi;
    logic [3:0] kp_seen;
    logic [2:0] op_at_eq;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .nRST(nRST), .col_n(col_n), .row_n(row_n),
        .keypad_input(keypad_input), .read_input(read_input),
        .operator_input(operator_input), .equal_input(equal_input),
        .clear_pulse(clear_pulse)
    );

    always #5 clk = ~clk;

    // Matrix model: a closed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (read_input) begin reads++; kp_seen = keypad_input; end
        if (equal_input) begin eqs++; op_at_eq = operator_input; end
        if (clear_pulse) clrs++;
        if (int'(read_input) + int'(equal_input) + int'(clear_pulse) > 1) multi++;
    endtask

    // Returns at the negedge just after row_n switched to the target row.
    task automatic wait_row(input logic [3:0] target);
        logic [3:0] prev;
        bit ok;
        ok = 0;
        prev = row_n;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row_n == target && prev != target) begin ok = 1; break; end
            prev = row_n;
        end
        if (!ok) chk("wait_row timeout", 32'd0, 32'd1);
    endtask

    task automatic clr_obs();
        reads = 0; eqs = 0; clrs = 0; kp_seen = 4'hx; op_at_eq = 3'bx;
    endtask

    task automatic run_key(input int row, input logic [15:0] mask);
        clr_obs();
        wait_row(4'b1111 ^ (4'b0001 << row));
        keys = mask;
        repeat (20) sample();
        keys = 16'h0;
        repeat (16) sample();
    endtask

    initial begin
        int bad_row;
        multi = 0;
        clr_obs();
        // reset state
        #2;
        chk("rst row_n", row_n, 4'b1110);
        chk("rst keypad", keypad_input, 4'd0);
        chk("rst read", read_input, 1'b0);
        chk("rst op", operator_input, 3'b000);
        chk("rst equal", equal_input, 1'b0);
        chk("rst clear", clear_pulse, 1'b0);
        @(negedge clk); @(negedge clk);
        nRST = 1'b1;

        // idle scan: rotate every 4 clocks, no strobes
        chk("scan row0", row_n, 4'b1110);
        for (int i = 1; i <= 8; i++) begin
            repeat (4) sample();
            chk($sformatf("scan row step %0d", i), row_n, 4'b1111 ^ (4'b0001 << (i % 4)));
        end
        chk("scan no strobes", reads + eqs + clrs, 0);

        // '5' held 40 clocks: one pulse at tick3 + 2 clocks, row held until release
        clr_obs();
        bad_row = 0;
        wait_row(4'b1101);
        keys = 16'h1 << 5;
        for (int k = 1; k <= 40; k++) begin
            sample();
            if (row_n != 4'b1101) bad_row++;
            if (k == 12) chk("5 no pulse early", read_input, 1'b0);
            if (k == 13) begin
                chk("5 pulse", read_input, 1'b1);
                chk("5 value", keypad_input, 4'd5);
            end
            if (k == 14) chk("5 pulse width", read_input, 1'b0);
        end
        chk("5 row held", bad_row, 0);
        chk("5 single pulse", reads, 1);
        keys = 16'h0;
        for (int k = 41; k <= 56; k++) begin
            sample();
            if (k == 51) chk("5 row held in release", row_n, 4'b1101);
            if (k == 52) chk("5 row advance", row_n, 4'b1011);
        end
        chk("5 no repeat", reads, 1);

        // '7' only two ticks: no strobe, scan resumes at row 3
        clr_obs();
        wait_row(4'b1011);
        keys = 16'h1 << 8;
        for (int k = 1; k <= 8; k++) sample();
        keys = 16'h0;
        for (int k = 9; k <= 20; k++) begin
            sample();
            if (k == 11) chk("7 row held", row_n, 4'b1011);
            if (k == 12) chk("7 row next", row_n, 4'b0111);
        end
        chk("7 no pulse", reads, 0);

        // 3, A, 4, #, 8
        run_key(0, 16'h1 << 2);
        chk("3 reads", reads, 1);
        chk("3 value", kp_seen, 4'd3);
        run_key(0, 16'h1 << 3);
        chk("A reads", reads, 0);
        chk("A op", operator_input, 3'b001);
        run_key(1, 16'h1 << 4);
        chk("4 value", kp_seen, 4'd4);
        chk("4 op kept", operator_input, 3'b001);
        run_key(3, 16'h1 << 14);
        chk("# equal", eqs, 1);
        chk("# op at equal", op_at_eq, 3'b001);
        chk("# no read", reads, 0);
        chk("# op after", operator_input, 3'b001);
        run_key(2, 16'h1 << 9);
        chk("8 value", kp_seen, 4'd8);
        chk("8 op cleared", operator_input, 3'b000);

        // 2 and 3 together: lowest column wins
        run_key(0, (16'h1 << 1) | (16'h1 << 2));
        chk("2+3 reads", reads, 1);
        chk("2+3 value", kp_seen, 4'd2);
        // D ignored
        run_key(3, 16'h1 << 15);
        chk("D no strobe", reads + eqs + clrs, 0);
        chk("D keypad kept", keypad_input, 4'd2);
        // C then '*'
        run_key(2, 16'h1 << 11);
        chk("C op", operator_input, 3'b100);
        run_key(3, 16'h1 << 12);
        chk("* clear", clrs, 1);
        chk("* op", operator_input, 3'b000);
        // B then reset during debounce of '9'
        run_key(1, 16'h1 << 7);
        chk("B op", operator_input, 3'b010);
        clr_obs();
        wait_row(4'b1011);
        keys = 16'h1 << 10;
        repeat (6) sample();
        nRST = 1'b0;
        #1;
        chk("rst9 row_n", row_n, 4'b1110);
        chk("rst9 keypad", keypad_input, 4'd0);
        chk("rst9 op", operator_input, 3'b000);
        chk("rst9 strobes", {read_input, equal_input, clear_pulse}, 3'b000);
        repeat (2) @(negedge clk);
        keys = 16'h0;
        nRST = 1'b1;
        #1;
        chk("rst9 scan restart", row_n, 4'b1110);
        repeat (20) sample();
        chk("rst9 no pulse", reads + eqs + clrs, 0);
        chk("no simultaneous strobes", multi, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
